// File: rtl/rc5_pkg.sv
// rc5_pkg: constants and types shared by the RC5-16 key-schedule block.
//   W, P16, Q16     : word width and the RC5-16 magic constants
//   KEY_WORDS       : 16-bit words in the 128-bit user key (L array depth)
//   MAX_SUBKEYS     : subkey table depth for 16 rounds, 2*(16+1)
//   word_t          : one 16-bit RC5 word
//   state_t + IDLE/INIT/MIX/DONE : key-expansion FSM encoding
package rc5_pkg;
  localparam int W           = 16;
  localparam int KEY_WORDS   = 8;
  localparam int MAX_SUBKEYS = 34;

  typedef logic [W-1:0] word_t;

  localparam word_t P16 = 16'hB7E1;
  localparam word_t Q16 = 16'h9E37;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t INIT = 2'd1;
  localparam state_t MIX  = 2'd2;
  localparam state_t DONE = 2'd3;
endpackage

// File: rtl/rc5_key_expand_rotl.sv
// rotl: combinational rotate-left of a W-bit word.
//   data_i : word to rotate
//   n_i    : rotate amount, only log2(W) bits are meaningful
//   data_o : rotated word
module rotl #(
  parameter int W = 16
) (
  input  logic [W-1:0]         data_i,
  input  logic [$clog2(W)-1:0] n_i,
  output logic [W-1:0]         data_o
);
  // The upper half of the doubled word shifted left is the rotation.
  logic [2*W-1:0] dbl;

  assign dbl    = {data_i, data_i} << n_i;
  assign data_o = dbl[2*W-1:W];
endmodule

// File: rtl/rc5_key_expand.sv
// rc5_key_expand: RC5-16 key schedule. Expands a 128-bit key into
// 2*(r+1) 16-bit subkeys (r = 0..16) and holds them on a flat bus for the
// round engine. One INIT write per cycle, then one full mix step per cycle.
//   clk, rst       : clock, asynchronous active-low reset
//   start          : expansion request, only sampled in IDLE
//   num_rounds     : round count r (values above 16 clamp to 16)
//   key            : user key, L[i] = key[16i+15:16i]
//   busy           : FSM is outside IDLE
//   done           : one-cycle pulse when the table is complete
//   subkeys_valid  : table is complete and stable
//   subkeys        : S[k] at [16k+15:16k], unused entries read 0
// Optional macro RC5_KEY_CACHE_EN: a repeated start with the same key and
// round count skips the expansion and pulses done one cycle later.
module rc5_key_expand
  import rc5_pkg::word_t, rc5_pkg::P16, rc5_pkg::Q16, rc5_pkg::KEY_WORDS,
         rc5_pkg::state_t, rc5_pkg::IDLE, rc5_pkg::INIT, rc5_pkg::MIX,
         rc5_pkg::DONE;
#(
  parameter int W          = 16,
  parameter int MAX_ROUNDS = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [4:0]                         num_rounds,
  input  logic [127:0]                       key,
  output logic                               busy,
  output logic                               done,
  output logic                               subkeys_valid,
  output logic [2*(MAX_ROUNDS+1)*W-1:0]      subkeys
);
  localparam int NSUB = 2 * (MAX_ROUNDS + 1);

  state_t     state_reg;
  logic [6:0] cnt_reg;
  logic [5:0] i_reg;
  logic [2:0] j_reg;
  logic [5:0] t_reg;
  logic [6:0] mix_len_reg;
  word_t      a_reg;
  word_t      b_reg;
  word_t      s_reg [NSUB];
  word_t      l_reg [KEY_WORDS];
  logic       valid_reg;

  // Schedule geometry derived from the request as presented in IDLE.
  logic [4:0] rc_in;
  logic [5:0] t_in;
  logic [5:0] m_in;
  logic [6:0] mix_len_in;

  assign rc_in      = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
  assign t_in       = {rc_in, 1'b0} + 6'd2;
  assign m_in       = (t_in < 6'd8) ? 6'd8 : t_in;
  assign mix_len_in = {1'b0, m_in} * 7'd3;

  // One full mix step: A' from S[i], then B' from L[j] using A'.
  word_t sum_a, a_new, ab_sum, sum_b, b_new, init_word;

  assign sum_a     = s_reg[i_reg] + a_reg + b_reg;
  assign ab_sum    = a_new + b_reg;
  assign sum_b     = l_reg[j_reg] + ab_sum;
  assign init_word = P16 + word_t'(cnt_reg) * Q16;

  rotl #(.W(W)) u_rot_a (.data_i(sum_a), .n_i(4'd3),        .data_o(a_new));
  rotl #(.W(W)) u_rot_b (.data_i(sum_b), .n_i(ab_sum[3:0]), .data_o(b_new));

  logic cache_hit;

`ifdef RC5_KEY_CACHE_EN
  logic [127:0] key_reg;
  logic [4:0]   rc_reg;
  logic [127:0] cache_key_reg;
  logic [4:0]   cache_rc_reg;
  logic         cache_ok_reg;

  assign cache_hit = cache_ok_reg && (key == cache_key_reg) && (rc_in == cache_rc_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_reg       <= '0;
      rc_reg        <= '0;
      cache_key_reg <= '0;
      cache_rc_reg  <= '0;
      cache_ok_reg  <= 1'b0;
    end else begin
      if (state_reg == IDLE && start && !cache_hit) begin
        key_reg <= key;
        rc_reg  <= rc_in;
      end
      // Remember what the finished table was built from.
      if (state_reg == MIX && cnt_reg == mix_len_reg - 7'd1) begin
        cache_key_reg <= key_reg;
        cache_rc_reg  <= rc_reg;
        cache_ok_reg  <= 1'b1;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      i_reg       <= '0;
      j_reg       <= '0;
      t_reg       <= '0;
      mix_len_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      valid_reg   <= 1'b0;
      for (int k = 0; k < NSUB; k++) s_reg[k] <= '0;
      for (int k = 0; k < KEY_WORDS; k++) l_reg[k] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (cache_hit) begin
              // Table already holds this key's schedule; just re-announce it.
              valid_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              for (int k = 0; k < NSUB; k++) s_reg[k] <= '0;
              for (int k = 0; k < KEY_WORDS; k++) l_reg[k] <= key[W*k +: W];
              t_reg       <= t_in;
              mix_len_reg <= mix_len_in;
              cnt_reg     <= '0;
              i_reg       <= '0;
              j_reg       <= '0;
              a_reg       <= '0;
              b_reg       <= '0;
              valid_reg   <= 1'b0;
              state_reg   <= INIT;
            end
          end
        end
        INIT: begin
          s_reg[cnt_reg[5:0]] <= init_word;
          if (cnt_reg == 7'(t_reg) - 7'd1) begin
            cnt_reg   <= '0;
            state_reg <= MIX;
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end
        MIX: begin
          s_reg[i_reg] <= a_new;
          l_reg[j_reg] <= b_new;
          a_reg        <= a_new;
          b_reg        <= b_new;
          i_reg        <= (i_reg == t_reg - 6'd1) ? 6'd0 : i_reg + 6'd1;
          j_reg        <= j_reg + 3'd1;
          if (cnt_reg == mix_len_reg - 7'd1) begin
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 7'd1;
          end
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign subkeys_valid = valid_reg;

  for (genvar gi = 0; gi < NSUB; gi++) begin : g_flat
    assign subkeys[gi*W +: W] = s_reg[gi];
  end
endmodule
